// File: rtl/btn_autorepeat.sv
// Press-and-hold auto-repeat: one tick on press, one after the hold delay, then one per repeat interval.
// Define AUTOREPEAT_ACCEL_EN to halve the repeat interval after ACCEL_AFTER repeat ticks of a press.
//
// state  | meaning
// IDLE   | waiting for press
// HOLD   | press tick issued, timing hold delay
// REPEAT | timing repeat interval
module btn_autorepeat #(
   parameter int HOLD_CYCLES   = 50_000_000,
   parameter int REPEAT_CYCLES = 10_000_000,
   parameter int ACCEL_AFTER   = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       level,
   input  logic       enable,
   output logic       tick,
   output logic [7:0] rpt_cnt
);

   localparam int MAX_CYCLES = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
   localparam int TW         = $clog2(MAX_CYCLES);

   typedef enum logic [1:0] {IDLE, HOLD, REPEAT} state_t;

   state_t        state, state_nxt;
   logic [TW-1:0] timer, timer_nxt;
   logic          tick_nxt;
   logic [7:0]    rpt_cnt_nxt;
   logic [7:0]    rpt_cnt_inc;
   logic [TW-1:0] hold_last;
   logic [TW-1:0] rep_last;

   assign hold_last   = TW'(HOLD_CYCLES - 1);
   assign rpt_cnt_inc = (rpt_cnt == 8'hFF) ? rpt_cnt : rpt_cnt + 8'd1;

`ifdef AUTOREPEAT_ACCEL_EN
   localparam int FAST_CYCLES = ((REPEAT_CYCLES >> 1) < 2) ? 2 : (REPEAT_CYCLES >> 1);
   localparam int AW          = $clog2(ACCEL_AFTER + 1);

   logic [AW-1:0] acc_cnt;
   logic          rep_event;

   assign rep_last = (acc_cnt == AW'(ACCEL_AFTER)) ? TW'(FAST_CYCLES - 1) : TW'(REPEAT_CYCLES - 1);

   // Counts repeat ticks of the current press; cleared whenever the press ends.
   always_ff @(posedge clk) begin
      if (reset || state_nxt == IDLE) begin
         acc_cnt <= '0;
      end else if (rep_event && acc_cnt != AW'(ACCEL_AFTER)) begin
         acc_cnt <= acc_cnt + AW'(1);
      end
   end
`else
   assign rep_last = TW'(REPEAT_CYCLES - 1);
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         timer   <= '0;
         tick    <= 1'b0;
         rpt_cnt <= 8'd0;
      end else begin
         state   <= state_nxt;
         timer   <= timer_nxt;
         tick    <= tick_nxt;
         rpt_cnt <= rpt_cnt_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      timer_nxt   = timer;
      tick_nxt    = 1'b0;
      rpt_cnt_nxt = rpt_cnt;
`ifdef AUTOREPEAT_ACCEL_EN
      rep_event   = 1'b0;
`endif
      if (!enable) begin
         state_nxt = IDLE;
         timer_nxt = '0;
      end else begin
         case (state)
            IDLE: begin
               timer_nxt = '0;
               if (level) begin
                  state_nxt   = HOLD;
                  tick_nxt    = 1'b1;
                  rpt_cnt_nxt = 8'd1;
               end
            end
            HOLD: begin
               if (!level) begin
                  state_nxt = IDLE;
                  timer_nxt = '0;
               end else if (timer == hold_last) begin
                  state_nxt   = REPEAT;
                  timer_nxt   = '0;
                  tick_nxt    = 1'b1;
                  rpt_cnt_nxt = rpt_cnt_inc;
`ifdef AUTOREPEAT_ACCEL_EN
                  rep_event   = 1'b1;
`endif
               end else begin
                  timer_nxt = timer + TW'(1);
               end
            end
            REPEAT: begin
               if (!level) begin
                  state_nxt = IDLE;
                  timer_nxt = '0;
               end else if (timer == rep_last) begin
                  timer_nxt   = '0;
                  tick_nxt    = 1'b1;
                  rpt_cnt_nxt = rpt_cnt_inc;
`ifdef AUTOREPEAT_ACCEL_EN
                  rep_event   = 1'b1;
`endif
               end else begin
                  timer_nxt = timer + TW'(1);
               end
            end
            default: begin
               state_nxt = IDLE;
               timer_nxt = '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_btn_autorepeat.sv
// Testbench for btn_autorepeat: directed scenarios plus random press patterns against a tick-schedule model.
// Honors AUTOREPEAT_ACCEL_EN the same way as the design.
module tb_btn_autorepeat;

   localparam int H = 8;
   localparam int R = 4;
   localparam int A = 3;
   localparam int F = ((R / 2) < 2) ? 2 : (R / 2);

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       level = 1'b0;
   logic       enable = 1'b1;
   logic       tick;
   logic [7:0] rpt_cnt;

   int checks = 0;
   int errors = 0;

   // Model: press active flag, edges since press edge, expected outputs.
   bit         m_active = 1'b0;
   int         m_n = 0;
   bit         m_tick = 1'b0;
   int         m_cnt = 0;
   int         long_hold_cnt;

   btn_autorepeat #(
      .HOLD_CYCLES  (H),
      .REPEAT_CYCLES(R),
      .ACCEL_AFTER  (A)
   ) dut (
      .clk    (clk),
      .reset  (reset),
      .level  (level),
      .enable (enable),
      .tick   (tick),
      .rpt_cnt(rpt_cnt)
   );

   always #5 clk = ~clk;

   // Is edge n (press edge = 0) of an uninterrupted hold a tick edge?
   function automatic bit sched(int n);
      int acc_pt;
      if (n == 0) return 1'b1;
      if (n < H) return 1'b0;
      acc_pt = H + (A - 1) * R;
`ifdef AUTOREPEAT_ACCEL_EN
      if (n > acc_pt) return ((n - acc_pt) % F) == 0;
`endif
      return ((n - H) % R) == 0;
   endfunction

   task automatic step(input bit r, input bit e, input bit l, input string tag);
      reset  = r;
      enable = e;
      level  = l;
      @(posedge clk);
      if (r) begin
         m_active = 1'b0;
         m_tick   = 1'b0;
         m_cnt    = 0;
      end else if (!e || !l) begin
         m_active = 1'b0;
         m_tick   = 1'b0;
      end else if (!m_active) begin
         m_active = 1'b1;
         m_n      = 0;
         m_tick   = 1'b1;
         m_cnt    = 1;
      end else begin
         m_n    = m_n + 1;
         m_tick = sched(m_n);
         if (m_tick && m_cnt < 255) m_cnt = m_cnt + 1;
      end
      #1;
      checks++;
      assert (tick === m_tick) else begin
         errors++;
         $error("FAIL %s tick observed %0b expected %0b at %0t", tag, tick, m_tick, $time);
      end
      checks++;
      assert (rpt_cnt === 8'(m_cnt)) else begin
         errors++;
         $error("FAIL %s rpt_cnt observed %0d expected %0d at %0t", tag, rpt_cnt, m_cnt, $time);
      end
   endtask

   initial begin
      repeat (2) step(1, 1, 0, "reset");
      repeat (3) step(0, 1, 0, "idle");

      repeat (3)  step(0, 1, 1, "short_press");
      repeat (20) step(0, 1, 0, "short_release");

      repeat (7) step(0, 1, 1, "pre_hold");
      repeat (5) step(0, 1, 0, "pre_hold_release");

      repeat (20) step(0, 1, 1, "long_hold");
`ifdef AUTOREPEAT_ACCEL_EN
      long_hold_cnt = 5;
`else
      long_hold_cnt = 4;
`endif
      checks++;
      assert (rpt_cnt === 8'(long_hold_cnt)) else begin
         errors++;
         $error("FAIL long_hold_total rpt_cnt observed %0d expected %0d", rpt_cnt, long_hold_cnt);
      end
      repeat (4) step(0, 1, 0, "long_release");

      repeat (13) step(0, 1, 1, "pre_reset_hold");
      step(1, 1, 1, "mid_reset");
      repeat (4) step(0, 1, 1, "post_reset_press");
      repeat (3) step(0, 1, 0, "post_reset_release");

      repeat (30) step(0, 0, 1, "enable_low");
      repeat (5)  step(0, 1, 1, "enable_rise");
      repeat (2)  step(0, 1, 0, "enable_release");

      repeat (1200) step(0, 1, 1, "saturate");
      checks++;
      assert (rpt_cnt === 8'd255) else begin
         errors++;
         $error("FAIL saturate_total rpt_cnt observed %0d expected 255", rpt_cnt);
      end
      repeat (3) step(0, 1, 0, "saturate_release");

      for (int s = 0; s < 300; s++) begin
         bit r, e, l;
         int len;
         r   = ($urandom_range(0, 19) == 0);
         e   = ($urandom_range(0, 9) != 0);
         l   = ($urandom_range(0, 2) != 0);
         len = $urandom_range(1, 30);
         repeat (len) step(r, e, l, "random");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
